// File: rtl/lcd_freq_display.sv
// Frequency readout pixel generator: shift-add-3 BCD conversion of data_fx, 9-digit 7-segment render.
// Optional LEADING_ZERO_BLANK_EN blanks digits above the most significant non-zero digit.
module lcd_freq_display #(
  parameter logic [10:0] X_START  = 11'd100,
  parameter logic [10:0] Y_START  = 11'd100,
  parameter logic [23:0] FG_COLOR = 24'hFF0000,
  parameter logic [23:0] BG_COLOR = 24'hFFFFFF
) (
  input  logic        lcd_pclk,
  input  logic        rst,
  input  logic [29:0] data_fx,
  input  logic        data_valid,
  input  logic [10:0] pixel_xpos,
  input  logic [10:0] pixel_ypos,
  output logic [23:0] pixel_data,
  output logic        busy,
  output logic        ovf
);

  localparam int unsigned BIN_W      = 30;
  localparam int unsigned NDIG       = 9;
  localparam int unsigned BCD_W      = 4 * NDIG;
  localparam int unsigned CELL_W     = 16;
  localparam int unsigned CELL_H     = 32;
  localparam int unsigned CELL_PITCH = 20;
  localparam logic [BIN_W-1:0] MAX_VAL = 30'd999_999_999;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, COMMIT} state_t;

  state_t           state_q, state_d;
  logic [BIN_W-1:0] bin_q;
  logic [BCD_W-1:0] bcd_q, bcd_adj_c, disp_q;
  logic [4:0]       iter_q;
  logic             ovf_pend_q;
  logic             latch_en, load_en, shift_en, commit_en, busy_d;

  function automatic logic [BCD_W-1:0] add3_nibbles(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int i = 0; i < 9; i++) begin
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Segment bits ordered {a,b,c,d,e,f,g}; codes 10-15 stay blank.
  function automatic logic [6:0] seg_map(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1111110;
      4'd1:    s = 7'b0110000;
      4'd2:    s = 7'b1101101;
      4'd3:    s = 7'b1111001;
      4'd4:    s = 7'b0110011;
      4'd5:    s = 7'b1011011;
      4'd6:    s = 7'b1011111;
      4'd7:    s = 7'b1110000;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1111011;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  always_ff @(posedge lcd_pclk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    latch_en  = 1'b0;
    load_en   = 1'b0;
    shift_en  = 1'b0;
    commit_en = 1'b0;
    busy_d    = 1'b1;
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (data_valid) begin
          latch_en = 1'b1;
          busy_d   = 1'b1;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        load_en = 1'b1;
        state_d = SHIFT;
      end
      SHIFT: begin
        shift_en = 1'b1;
        if (iter_q == 5'd29) state_d = COMMIT;
      end
      COMMIT: begin
        // Only swap digits during vertical blanking so a frame never tears.
        if (pixel_ypos == 11'd0) begin
          commit_en = 1'b1;
          busy_d    = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb bcd_adj_c = add3_nibbles(bcd_q);

  always_ff @(posedge lcd_pclk) begin
    if (rst) begin
      busy       <= 1'b0;
      ovf        <= 1'b0;
      bin_q      <= '0;
      bcd_q      <= '0;
      iter_q     <= '0;
      ovf_pend_q <= 1'b0;
      disp_q     <= '0;
    end else begin
      busy <= busy_d;
      if (latch_en) bin_q <= data_fx;
      if (load_en) begin
        if (bin_q > MAX_VAL) begin
          bin_q      <= MAX_VAL;
          ovf_pend_q <= 1'b1;
        end else begin
          ovf_pend_q <= 1'b0;
        end
        bcd_q  <= '0;
        iter_q <= '0;
      end
      if (shift_en) begin
        bcd_q  <= {bcd_adj_c[BCD_W-2:0], bin_q[BIN_W-1]};
        bin_q  <= {bin_q[BIN_W-2:0], 1'b0};
        iter_q <= iter_q + 5'd1;
      end
      if (commit_en) begin
        disp_q <= bcd_q;
        ovf    <= ovf_pend_q;
      end
    end
  end

  logic        in_win_c, shown_c, lit_c;
  logic [10:0] dx_c, base_c;
  logic [3:0]  cell_c, dig_idx_c, digit_c;
  logic [4:0]  cx_c, cy_c;
  logic [6:0]  segs_c, hit_c;

  // Cell index and cell-local x found by compares against the fixed pitch.
  always_comb begin
    in_win_c = (pixel_xpos >= X_START) &&
               ({1'b0, pixel_xpos} <= {1'b0, X_START} + 12'(NDIG * CELL_PITCH - 1)) &&
               (pixel_ypos >= Y_START) &&
               ({1'b0, pixel_ypos} <= {1'b0, Y_START} + 12'(CELL_H - 1));
    dx_c   = pixel_xpos - X_START;
    cy_c   = 5'(pixel_ypos - Y_START);
    cell_c = 4'd0;
    base_c = 11'd0;
    for (int i = 1; i < 9; i++) begin
      if (dx_c >= 11'(CELL_PITCH * i)) begin
        cell_c = 4'(i);
        base_c = 11'(CELL_PITCH * i);
      end
    end
    cx_c      = 5'(dx_c - base_c);
    dig_idx_c = 4'(NDIG - 1) - cell_c;
    digit_c   = disp_q[{dig_idx_c, 2'b00} +: 4];
    segs_c    = seg_map(digit_c);
    hit_c[6]  = (cy_c <= 5'd2) && (cx_c >= 5'd2) && (cx_c <= 5'd13);
    hit_c[5]  = (cx_c >= 5'd13) && (cx_c <= 5'd15) && (cy_c >= 5'd2) && (cy_c <= 5'd15);
    hit_c[4]  = (cx_c >= 5'd13) && (cx_c <= 5'd15) && (cy_c >= 5'd16) && (cy_c <= 5'd29);
    hit_c[3]  = (cy_c >= 5'd29) && (cx_c >= 5'd2) && (cx_c <= 5'd13);
    hit_c[2]  = (cx_c <= 5'd2) && (cy_c >= 5'd16) && (cy_c <= 5'd29);
    hit_c[1]  = (cx_c <= 5'd2) && (cy_c >= 5'd2) && (cy_c <= 5'd15);
    hit_c[0]  = (cy_c >= 5'd14) && (cy_c <= 5'd16) && (cx_c >= 5'd2) && (cx_c <= 5'd13);
    lit_c     = in_win_c && (cx_c < 5'(CELL_W)) && shown_c && (|(segs_c & hit_c));
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [NDIG-1:0] show_c;

  // A digit is drawn if it or any more significant digit is non-zero; digit 0 always.
  always_comb begin
    show_c[8] = (disp_q[35:32] != 4'd0);
    for (int i = 7; i >= 1; i--) begin
      show_c[i] = show_c[i+1] | (disp_q[4*i +: 4] != 4'd0);
    end
    show_c[0] = 1'b1;
  end

  assign shown_c = show_c[dig_idx_c];
`else
  assign shown_c = 1'b1;
`endif

  always_ff @(posedge lcd_pclk) begin
    if (rst) pixel_data <= BG_COLOR;
    else     pixel_data <= lit_c ? FG_COLOR : BG_COLOR;
  end

endmodule
